// File: rtl/fwrisc_mem_arb.sv
// fwrisc_mem_arb: three-way arbiter for one single-port synchronous 32-bit memory.
// Requesters: UART program loader, core data port and core instruction port.
// The grant is combinational on the memory port in cycle N. The owner is registered
// and its ready pulses in cycle N+1, together with the read data.
// Optional build macro FWRISC_MEM_ARB_STATS_EN adds grant and stall counters.
module fwrisc_mem_arb #(
  parameter int MEM_AW   = 12,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_active,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ready,
  input  logic              dvalid,
  input  logic [31:0]       daddr,
  input  logic [31:0]       dwdata,
  input  logic [3:0]        dstrb,
  input  logic              dwrite,
  output logic [31:0]       drdata,
  output logic              dready,
  input  logic              ivalid,
  input  logic [31:0]       iaddr,
  output logic [31:0]       idata,
  output logic              iready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_strb,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef FWRISC_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_i_stall
`endif
);

  localparam int SW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_D    = 2'd2,
    OWN_I    = 2'd3
  } owner_t;

  owner_t          g_q;
  owner_t          gnt;
  logic [SW-1:0]   starve_cnt;
  logic            ld_req;
  logic            d_req;
  logic            i_elig;
  logic            i_req;
  logic            starved;

  // Only the word-address bits of each byte address reach the memory.
  logic            unused_addr_bits;
  assign unused_addr_bits = &{1'b0, ld_addr, daddr, iaddr};

  // Arbitration: the requester being answered this cycle sits out; reset blocks all grants.
  always_comb begin
    ld_req  = ld_valid && (g_q != OWN_LD);
    d_req   = dvalid && (g_q != OWN_D);
    i_elig  = ivalid && !load_active;
    i_req   = i_elig && (g_q != OWN_I);
    starved = (starve_cnt == SW'(MAX_WAIT));
    gnt     = OWN_NONE;
    if (!reset) begin
      if (ld_req)                gnt = OWN_LD;
      else if (starved && i_req) gnt = OWN_I;
      else if (d_req)            gnt = OWN_D;
      else if (i_req)            gnt = OWN_I;
    end
  end

  // Memory port driven directly from the winner in the grant cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_strb  = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    case (gnt)
      OWN_LD: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_strb  = 4'hF;
        mem_addr  = ld_addr[MEM_AW+1:2];
        mem_wdata = ld_wdata;
      end
      OWN_D: begin
        mem_en    = 1'b1;
        mem_we    = dwrite;
        mem_strb  = dstrb;
        mem_addr  = daddr[MEM_AW+1:2];
        mem_wdata = dwdata;
      end
      OWN_I: begin
        mem_en    = 1'b1;
        mem_addr  = iaddr[MEM_AW+1:2];
      end
      default: ;
    endcase
  end

  // Grant owner register and instruction starvation counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      g_q        <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      g_q <= gnt;
      if ((gnt == OWN_I) || !i_elig)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Completion side: reset suppresses a ready still pending from the previous grant.
  assign ld_ready = (g_q == OWN_LD) && !reset;
  assign dready   = (g_q == OWN_D) && !reset;
  assign iready   = (g_q == OWN_I) && !reset;
  assign drdata   = dready ? mem_rdata : 32'h0;
  assign idata    = iready ? mem_rdata : 32'h0;

`ifdef FWRISC_MEM_ARB_STATS_EN
  // Wrapping grant and fetch-stall counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_d_grants <= 32'h0;
      stat_i_grants <= 32'h0;
      stat_i_stall  <= 32'h0;
    end else begin
      if (gnt == OWN_D)            stat_d_grants <= stat_d_grants + 32'h1;
      if (gnt == OWN_I)            stat_i_grants <= stat_i_grants + 32'h1;
      if (i_elig && gnt != OWN_I)  stat_i_stall  <= stat_i_stall + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_fwrisc_mem_arb.sv
// tb_fwrisc_mem_arb: directed bench for fwrisc_mem_arb (default build, stats disabled).
module tb_fwrisc_mem_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_active;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ready;
  logic        dvalid;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dstrb;
  logic        dwrite;
  logic [31:0] drdata;
  logic        dready;
  logic        ivalid;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        iready;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_strb;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  fwrisc_mem_arb #(.MEM_AW(12), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset), .load_active(load_active),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .dvalid(dvalid), .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb), .dwrite(dwrite),
    .drdata(drdata), .dready(dready),
    .ivalid(ivalid), .iaddr(iaddr), .idata(idata), .iready(iready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_strb(mem_strb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_addr [7];
    exp_addr = '{32'h40, 32'h80, 32'h40, 32'h80, 32'h40, 32'hC0, 32'h40};

    reset = 1'b1; load_active = 1'b0;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
    dvalid = 1'b0; daddr = 32'h0; dwdata = 32'h0; dstrb = 4'h0; dwrite = 1'b0;
    ivalid = 1'b1; iaddr = 32'h8000_0010; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clock); @(posedge clock);

    // reset state, with a fetch request already presented
    @(negedge clock); #1;
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_strb", 32'(mem_strb), 32'h0);
    chk("rst_ready", 32'({ld_ready, dready, iready}), 32'h0);
    chk("rst_rdata", drdata | idata, 32'h0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'h0);

    // fetch only
    @(negedge clock); reset = 1'b0; mem_rdata = 32'h0; #1;
    chk("f1_mem_en", 32'(mem_en), 32'h1);
    chk("f1_mem_we", 32'(mem_we), 32'h0);
    chk("f1_mem_strb", 32'(mem_strb), 32'h0);
    chk("f1_mem_addr", 32'(mem_addr), 32'h4);
    @(negedge clock); mem_rdata = 32'h0000_0013; #1;
    chk("f1_iready", 32'(iready), 32'h1);
    chk("f1_idata", idata, 32'h13);
    chk("f1_no_regrant", 32'(mem_en), 32'h0);
    @(negedge clock); ivalid = 1'b0; mem_rdata = 32'h0; #1;
    chk("f1_iready_off", 32'(iready), 32'h0);
    chk("f1_idata_zero", idata, 32'h0);

    // data beats fetch, fetch follows while dready is high
    @(negedge clock);
    dvalid = 1'b1; dwrite = 1'b0; dstrb = 4'h0; daddr = 32'h8000_2004;
    ivalid = 1'b1; iaddr = 32'h8000_0020; #1;
    chk("p2_d_grant", 32'(mem_en), 32'h1);
    chk("p2_d_addr", 32'(mem_addr), 32'h801);
    chk("p2_d_we", 32'(mem_we), 32'h0);
    @(negedge clock); mem_rdata = 32'hCAFE_0001; #1;
    chk("p2_dready", 32'(dready), 32'h1);
    chk("p2_drdata", drdata, 32'hCAFE_0001);
    chk("p2_i_grant", 32'(mem_en), 32'h1);
    chk("p2_i_addr", 32'(mem_addr), 32'h8);
    chk("p2_iready_early", 32'(iready), 32'h0);
    @(negedge clock); dvalid = 1'b0; ivalid = 1'b0; mem_rdata = 32'h0000_0093; #1;
    chk("p2_iready", 32'(iready), 32'h1);
    chk("p2_idata", idata, 32'h93);
    chk("p2_dready_off", 32'(dready), 32'h0);
    chk("p2_drdata_zero", drdata, 32'h0);

    // back-to-back data reads with a fetch pending
    @(negedge clock);
    mem_rdata = 32'h0;
    dvalid = 1'b1; daddr = 32'h8000_0100; ivalid = 1'b1; iaddr = 32'h8000_0030; #1;
    chk("b2b_d_addr", 32'(mem_addr), 32'h40);
    @(negedge clock); #1;
    chk("b2b_i_addr", 32'(mem_addr), 32'hC);
    chk("b2b_i_we", 32'(mem_we), 32'h0);
    chk("b2b_dready", 32'(dready), 32'h1);
    @(negedge clock); #1;
    chk("b2b_d2_addr", 32'(mem_addr), 32'h40);
    chk("b2b_iready", 32'(iready), 32'h1);
    chk("b2b_starve_clr", 32'(dut.starve_cnt), 32'h0);
    @(negedge clock); dvalid = 1'b0; ivalid = 1'b0; #1;
    chk("b2b_dready2", 32'(dready), 32'h1);
    chk("b2b_idle", 32'(mem_en), 32'h0);

    // loader and data alternate; the fetch wins once the starvation limit is reached
    @(negedge clock);
    ld_valid = 1'b1; ld_addr = 32'h100; ld_wdata = 32'h1111_1111;
    dvalid = 1'b1; daddr = 32'h200; ivalid = 1'b1; iaddr = 32'h300;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      chk($sformatf("stv_addr%0d", k), 32'(mem_addr), exp_addr[k]);
      if (k == 5) begin
        chk("stv_cnt_max", 32'(dut.starve_cnt), 32'h4);
        chk("stv_fetch_we", 32'(mem_we), 32'h0);
      end
      if (k == 6) chk("stv_cnt_clr", 32'(dut.starve_cnt), 32'h0);
    end
    @(negedge clock); ld_valid = 1'b0; dvalid = 1'b0; ivalid = 1'b0; #1;
    chk("stv_ld_ready", 32'(ld_ready), 32'h1);
    chk("stv_idle", 32'(mem_en), 32'h0);
    @(negedge clock);

    // program load blocks fetch
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      load_active = 1'b1; ld_valid = 1'b1; ld_addr = 32'(k * 4); ld_wdata = 32'hDEAD_BEEF;
      ivalid = 1'b1; iaddr = 32'h8000_0050; #1;
      chk($sformatf("ld%0d_we", k), 32'({mem_en, mem_we}), 32'h3);
      chk($sformatf("ld%0d_strb", k), 32'(mem_strb), 32'hF);
      chk($sformatf("ld%0d_addr", k), 32'(mem_addr), 32'(k));
      chk($sformatf("ld%0d_wdata", k), mem_wdata, 32'hDEAD_BEEF);
      @(negedge clock); #1;
      chk($sformatf("ld%0d_ready", k), 32'(ld_ready), 32'h1);
      chk($sformatf("ld%0d_no_fetch", k), 32'({mem_en, iready}), 32'h0);
    end
    @(negedge clock); ld_valid = 1'b0; #1;
    chk("ld_hold_fetch", 32'({mem_en, iready, ld_ready}), 32'h0);
    @(negedge clock); load_active = 1'b0; #1;
    chk("ld_end_fetch", 32'(mem_en), 32'h1);
    chk("ld_end_addr", 32'(mem_addr), 32'h14);
    @(negedge clock); ivalid = 1'b0; mem_rdata = 32'h0000_0073; #1;
    chk("ld_end_iready", 32'(iready), 32'h1);
    chk("ld_end_idata", idata, 32'h73);

    // partial-strobe data write
    @(negedge clock);
    mem_rdata = 32'h0;
    dvalid = 1'b1; dwrite = 1'b1; dstrb = 4'b0101; dwdata = 32'hAABB_CCDD; daddr = 32'h8000_0040; #1;
    chk("wr_we", 32'({mem_en, mem_we}), 32'h3);
    chk("wr_strb", 32'(mem_strb), 32'h5);
    chk("wr_wdata", mem_wdata, 32'hAABB_CCDD);
    chk("wr_addr", 32'(mem_addr), 32'h10);
    @(negedge clock); dvalid = 1'b0; dwrite = 1'b0; dstrb = 4'h0; #1;
    chk("wr_dready", 32'(dready), 32'h1);
    chk("wr_drdata", drdata, 32'h0);

    // reset between grant and completion
    @(negedge clock); dvalid = 1'b1; daddr = 32'h8000_0080; #1;
    chk("rg_grant", 32'(mem_en), 32'h1);
    chk("rg_addr", 32'(mem_addr), 32'h20);
    @(negedge clock); reset = 1'b1; mem_rdata = 32'h55; #1;
    chk("rg_no_dready", 32'(dready), 32'h0);
    chk("rg_no_drdata", drdata, 32'h0);
    chk("rg_no_grant", 32'(mem_en), 32'h0);
    @(negedge clock); reset = 1'b0; dvalid = 1'b0; mem_rdata = 32'h0; #1;
    chk("rg_ready_after", 32'({ld_ready, dready, iready}), 32'h0);
    chk("rg_mem_after", 32'({mem_en, mem_we, mem_strb}), 32'h0);
    chk("rg_rdata_after", drdata | idata, 32'h0);
    chk("rg_starve_after", 32'(dut.starve_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
